// File: rtl/header_field_parser_if.sv
// rtl/header_field_parser_if.sv - byte stream handshake between a source and the header parser
interface header_field_parser_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/header_field_parser.sv
// rtl/header_field_parser.sv - sync-hunting camera header parser with XOR check and idle timeout
module header_field_parser #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    header_field_parser_if.slave         stream,
    output logic [7:0]                   profile,
    output logic [15:0]                  width,
    output logic [15:0]                  height,
    output logic [7:0]                   fps,
    output logic [1:0]                   chroma_format,
    output logic [3:0]                   bit_depth,
    output logic [5:0]                   qp,
    output logic                         tiles_enabled,
    output logic [3:0]                   tile_cols,
    output logic [3:0]                   tile_rows,
    output logic                         hdr_valid,
    output logic                         hdr_err,
    output logic [1:0]                   err_code
);

    typedef enum logic [1:0] {HUNT, PAYLOAD, EMIT} state_t;

    // The idle counter fires on the edge where it would reach TIMEOUT,
    // so the comparison is made against TIMEOUT-1 before incrementing.
    localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 1);

    state_t      state;
    logic [3:0]  idx;
    logic [7:0]  xor_acc;
    logic [15:0] idle_cnt;
    logic        xfer;

    // Shadow copies of the fields, only published on a good checksum.
    logic [7:0]  sh_profile;
    logic [15:0] sh_width;
    logic [15:0] sh_height;
    logic [7:0]  sh_fps;
    logic [1:0]  sh_chroma;
    logic [3:0]  sh_depth;
    logic [5:0]  sh_qp;
    logic        sh_tiles;
    logic [3:0]  sh_cols;
    logic [3:0]  sh_rows;

    assign xfer = stream.in_valid && stream.in_ready;

    // Hunt / payload / emit sequencer with registered ready, strobes and fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= HUNT;
            stream.in_ready <= 1'b1;
            idx             <= '0;
            xor_acc         <= '0;
            idle_cnt        <= '0;
            hdr_valid       <= 1'b0;
            hdr_err         <= 1'b0;
            err_code        <= 2'b00;
            profile         <= '0;
            width           <= '0;
            height          <= '0;
            fps             <= '0;
            chroma_format   <= '0;
            bit_depth       <= '0;
            qp              <= '0;
            tiles_enabled   <= 1'b0;
            tile_cols       <= '0;
            tile_rows       <= '0;
            sh_profile      <= '0;
            sh_width        <= '0;
            sh_height       <= '0;
            sh_fps          <= '0;
            sh_chroma       <= '0;
            sh_depth        <= '0;
            sh_qp           <= '0;
            sh_tiles        <= 1'b0;
            sh_cols         <= '0;
            sh_rows         <= '0;
        end else begin
            hdr_valid <= 1'b0;
            hdr_err   <= 1'b0;
            case (state)
                HUNT: begin
                    if (xfer && stream.in_data == SYNC_BYTE) begin
                        idx      <= '0;
                        xor_acc  <= '0;
                        idle_cnt <= '0;
                        state    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        xor_acc  <= xor_acc ^ stream.in_data;
                        if (idx == 4'd9) begin
                            state           <= EMIT;
                            stream.in_ready <= 1'b0;
                            if ((xor_acc ^ stream.in_data) == 8'h00) begin
                                hdr_valid     <= 1'b1;
                                profile       <= sh_profile;
                                width         <= sh_width;
                                height        <= sh_height;
                                fps           <= sh_fps;
                                chroma_format <= sh_chroma;
                                bit_depth     <= sh_depth;
                                qp            <= sh_qp;
                                tiles_enabled <= sh_tiles;
                                tile_cols     <= sh_cols;
                                tile_rows     <= sh_rows;
                            end else begin
                                hdr_err  <= 1'b1;
                                err_code <= 2'b01;
                            end
                        end else begin
                            idx <= idx + 4'd1;
                            case (idx)
                                4'd0: sh_profile       <= stream.in_data;
                                4'd1: sh_width[15:8]   <= stream.in_data;
                                4'd2: sh_width[7:0]    <= stream.in_data;
                                4'd3: sh_height[15:8]  <= stream.in_data;
                                4'd4: sh_height[7:0]   <= stream.in_data;
                                4'd5: sh_fps           <= stream.in_data;
                                4'd6: begin
                                    sh_chroma <= stream.in_data[7:6];
                                    sh_depth  <= stream.in_data[5:2];
                                end
                                4'd7: begin
                                    sh_tiles <= stream.in_data[7];
                                    sh_qp    <= stream.in_data[5:0];
                                end
                                default: begin
                                    sh_cols <= stream.in_data[7:4];
                                    sh_rows <= stream.in_data[3:0];
                                end
                            endcase
                        end
                    end else if (idle_cnt == IDLE_LIMIT) begin
                        state           <= EMIT;
                        stream.in_ready <= 1'b0;
                        idle_cnt        <= '0;
                        hdr_err         <= 1'b1;
                        err_code        <= 2'b10;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end
                EMIT: begin
                    state           <= HUNT;
                    stream.in_ready <= 1'b1;
                end
                default: begin
                    state           <= HUNT;
                    stream.in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_header_field_parser.sv
// tb/tb_header_field_parser.sv - randomized and directed bench for header_field_parser
module tb_header_field_parser;

    localparam int         TO   = 8;
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    header_field_parser_if ifc ();

    logic [7:0]  profile;
    logic [15:0] width;
    logic [15:0] height;
    logic [7:0]  fps;
    logic [1:0]  chroma_format;
    logic [3:0]  bit_depth;
    logic [5:0]  qp;
    logic        tiles_enabled;
    logic [3:0]  tile_cols;
    logic [3:0]  tile_rows;
    logic        hdr_valid;
    logic        hdr_err;
    logic [1:0]  err_code;

    header_field_parser #(.SYNC_BYTE(SYNC), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .stream        (ifc),
        .profile       (profile),
        .width         (width),
        .height        (height),
        .fps           (fps),
        .chroma_format (chroma_format),
        .bit_depth     (bit_depth),
        .qp            (qp),
        .tiles_enabled (tiles_enabled),
        .tile_cols     (tile_cols),
        .tile_rows     (tile_rows),
        .hdr_valid     (hdr_valid),
        .hdr_err       (hdr_err),
        .err_code      (err_code)
    );

    wire [68:0] obs_fields = {profile, width, height, fps, chroma_format, bit_depth,
                              qp, tiles_enabled, tile_cols, tile_rows};

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_err   = 0;
    int exp_nv  = 0;
    int exp_ne  = 0;
    logic [68:0] exp_fields = '0;

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode from the wire-format rules using plain arithmetic.
    function automatic logic [68:0] decode(input logic [7:0] p [9]);
        int w, h, chroma, depth, q, tiles, cols, rows;
        w      = int'(p[1]) * 256 + int'(p[2]);
        h      = int'(p[3]) * 256 + int'(p[4]);
        chroma = int'(p[6]) / 64;
        depth  = (int'(p[6]) / 4) % 16;
        tiles  = int'(p[7]) / 128;
        q      = int'(p[7]) % 64;
        cols   = int'(p[8]) / 16;
        rows   = int'(p[8]) % 16;
        return {p[0], 16'(w), 16'(h), p[5], 2'(chroma), 4'(depth), 6'(q), 1'(tiles),
                4'(cols), 4'(rows)};
    endfunction

    function automatic logic [7:0] xsum(input logic [7:0] p [9]);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 9; i++) r = r ^ p[i];
        return r;
    endfunction

    // Strobe observer: counts strobes and checks they never coincide.
    always @(negedge clk) begin
        if (!reset) begin
            if (hdr_valid) n_valid++;
            if (hdr_err) n_err++;
            if (hdr_valid || hdr_err) check("strobe_exclusive", hdr_valid && hdr_err, 0);
        end
    end

    task automatic push_byte(input logic [7:0] b, input int gap);
        logic done = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            ifc.in_valid = 1'b0;
        end
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            ifc.in_valid = 1'b1;
            ifc.in_data  = b;
            if (ifc.in_ready) done = 1'b1;
        end
        if (!done) check("push_timeout", 0, 1);
    endtask

    task automatic run_header(input string tag, input logic [7:0] p [9], input logic [7:0] chk,
                              input int gmin, input int gmax, input int ngarbage);
        logic [7:0] g;
        logic       good;
        for (int i = 0; i < ngarbage; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == SYNC) g = 8'h00;
            push_byte(g, $urandom_range(gmin, gmax));
        end
        push_byte(SYNC, $urandom_range(gmin, gmax));
        for (int k = 0; k < 9; k++) push_byte(p[k], $urandom_range(gmin, gmax));
        push_byte(chk, $urandom_range(gmin, gmax));
        @(negedge clk);
        ifc.in_valid = 1'b0;
        good = (xsum(p) == chk);
        if (good) begin
            exp_fields = decode(p);
            exp_nv++;
        end else begin
            exp_ne++;
        end
        check({tag, "_valid"}, hdr_valid, good);
        check({tag, "_err"}, hdr_err, !good);
        if (!good) check({tag, "_code"}, err_code, 2'b01);
        check({tag, "_fields"}, obs_fields, exp_fields);
        check({tag, "_emit_ready"}, ifc.in_ready, 0);
        @(negedge clk);
        check({tag, "_strobe_drop"}, hdr_valid | hdr_err, 0);
        check({tag, "_hunt_ready"}, ifc.in_ready, 1);
    endtask

    initial begin
        logic [7:0] p1 [9];
        logic [7:0] p3 [9];
        logic [7:0] pt [9];
        logic [7:0] pr [9];
        logic [7:0] c;
        int seen_v, seen_e;

        p1 = '{8'h01, 8'h07, 8'h80, 8'h04, 8'h40, 8'h1E, 8'h60, 8'h1A, 8'h00};
        p3 = p1;
        p3[0] = 8'h02;
        pt = p1;
        pt[7] = 8'h9A;
        pt[8] = 8'h34;

        reset = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_fields", obs_fields, 0);
        check("rst_valid", hdr_valid, 0);
        check("rst_err", hdr_err, 0);
        check("rst_code", err_code, 0);
        check("rst_ready", ifc.in_ready, 1);
        reset = 1'b0;

        // Good header at full rate, then checksum-corrupted copy.
        run_header("good_full", p1, 8'hA6, 0, 0, 0);
        check("good_profile", profile, 1);
        check("good_width", width, 1920);
        check("good_height", height, 1088);
        check("good_depth", bit_depth, 8);
        run_header("bad_chk", p1, 8'hA7, 0, 0, 0);

        // Garbage before sync with in_valid on alternating cycles.
        push_byte(8'h00, 1);
        push_byte(8'hFF, 1);
        push_byte(8'h12, 1);
        run_header("garbage_alt", p3, xsum(p3), 1, 1, 0);

        // Stall after k4: error exactly TO edges after the last transfer.
        push_byte(SYNC, 0);
        for (int k = 0; k < 4; k++) push_byte(p1[k], 0);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            if (i < TO) check("stall_early", hdr_err, 0);
        end
        exp_ne++;
        check("stall_err", hdr_err, 1);
        check("stall_code", err_code, 2'b10);
        check("stall_valid", hdr_valid, 0);
        check("stall_fields", obs_fields, exp_fields);
        run_header("after_stall", p1, 8'hA6, 0, 0, 0);

        // A transfer on the edge the counter would expire wins.
        run_header("edge_gap", p3, xsum(p3), TO - 1, TO - 1, 0);

        run_header("tiles", pt, xsum(pt), 0, 0, 0);
        check("tiles_en", tiles_enabled, 1);
        check("tiles_qp", qp, 26);
        check("tiles_cols", tile_cols, 3);
        check("tiles_rows", tile_rows, 4);

        // Reset pulsed mid-header after k6.
        push_byte(SYNC, 0);
        for (int k = 0; k < 6; k++) push_byte(p1[k], 0);
        @(negedge clk);
        seen_v = n_valid;
        seen_e = n_err;
        reset = 1'b1;
        ifc.in_valid = 1'b0;
        #1;
        check("midrst_fields", obs_fields, 0);
        check("midrst_strobes", {hdr_valid, hdr_err}, 0);
        check("midrst_code", err_code, 0);
        check("midrst_ready", ifc.in_ready, 1);
        exp_fields = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_strobe", n_valid + n_err, seen_v + seen_e);
        run_header("after_rst", p1, 8'hA6, 0, 0, 0);

        // Randomized headers, some with corrupted checksums.
        for (int n = 0; n < 25; n++) begin
            for (int k = 0; k < 9; k++) pr[k] = 8'($urandom_range(0, 255));
            c = xsum(pr);
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            run_header($sformatf("rand%0d", n), pr, c, 0, 3, $urandom_range(0, 2));
        end

        check("count_valid", n_valid, exp_nv);
        check("count_err", n_err, exp_ne);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
